// File: rtl/rmii_frame_tx.sv
// rmii_frame_tx: RMII-side Ethernet frame transmitter (PHY clock domain).
// Accepts one 128-bit payload word per frame from a show-ahead source and
// serialises preamble, SFD, header, payload, zero pad and FCS as dibits.
// Optional build macro RMII_TX_10M_EN selects 10 Mb/s RMII timing: each
// dibit is held for 10 clk cycles by a 4-bit prescaler. Without it, the
// block runs at 100 Mb/s (one dibit per clk) and has no prescaler.
`timescale 1ns/1ps
module rmii_frame_tx #(
  parameter logic [47:0] SRC_MAC   = 48'hAE6176545AD6,
  parameter logic [15:0] ETH_TYPE  = 16'hC0DE,
  parameter int unsigned IFG_BYTES = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         valid,
  input  logic [127:0] data,
  input  logic [47:0]  dst_mac,
  output logic         ready,
  output logic [1:0]   tx_d,
  output logic         tx_en
);

  // Handshake: a word transfers on a rising clk edge where valid && ready.
  // ready is registered and high only while the FSM idles; data/dst_mac are
  // sampled only in that transfer cycle, and valid at any other time is ignored.

  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_SFD, S_HDR, S_PAY, S_PAD, S_FCS, S_IFG
  } state_t;

  // state/byte_cnt/dib_cnt describe the dibit slot currently on tx_d
  state_t        state;
  logic [6:0]    byte_cnt;
  logic [1:0]    dib_cnt;
  logic [31:0]   crc;
  logic [127:0]  pay_q;
  logic [47:0]   dst_q;

  state_t        nxt_state;
  logic [6:0]    nxt_byte;
  logic [1:0]    nxt_dib;
  logic          nxt_en;
  logic [1:0]    nxt_dibit;
  logic [6:0]    last_byte;
  logic [31:0]   crc_nxt;
  logic [31:0]   fcs_w;
  logic [111:0]  hdr_w;
  logic [7:0]    cur_byte;
  logic          step;
  logic          ifg_done;

  // Reflected CRC-32 advanced by one dibit, bit 0 first
  function automatic logic [31:0] crc_dibit(input logic [31:0] c, input logic [1:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 2; i++) begin
      r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction

`ifdef RMII_TX_10M_EN
  logic [3:0] presc;

  // Prescaler: one tick every 10 clk cycles while a frame or gap is running
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc <= '0;
    end else if (state == S_IDLE || presc == 4'd9) begin
      presc <= '0;
    end else begin
      presc <= presc + 4'd1;
    end
  end

  assign step = (presc == 4'd9);
  // Gap ends one cycle early so the ready cycle in IDLE completes the gap
  assign ifg_done = (state == S_IFG) && (byte_cnt == last_byte) &&
                    (dib_cnt == 2'd3) && (presc == 4'd8);
`else
  assign step = 1'b1;
  // Gap ends one cycle early so the ready cycle in IDLE completes the gap
  assign ifg_done = (state == S_IFG) && (byte_cnt == last_byte) && (dib_cnt == 2'd2);
`endif

  assign hdr_w = {dst_q, SRC_MAC, ETH_TYPE};
  assign fcs_w = ~crc_nxt;

  // Index of the final byte of the current state
  always_comb begin
    case (state)
      S_PRE:   last_byte = 7'd6;
      S_SFD:   last_byte = 7'd0;
      S_HDR:   last_byte = 7'd13;
      S_PAY:   last_byte = 7'd15;
      S_PAD:   last_byte = 7'd29;
      S_FCS:   last_byte = 7'd3;
      default: last_byte = 7'(IFG_BYTES - 1);
    endcase
  end

  // Next dibit slot: counters clear on every state change
  always_comb begin
    nxt_state = state;
    nxt_byte  = byte_cnt;
    nxt_dib   = dib_cnt + 2'd1;
    if (dib_cnt == 2'd3) begin
      nxt_dib = 2'd0;
      if (byte_cnt == last_byte) begin
        nxt_byte = '0;
        case (state)
          S_PRE:   nxt_state = S_SFD;
          S_SFD:   nxt_state = S_HDR;
          S_HDR:   nxt_state = S_PAY;
          S_PAY:   nxt_state = S_PAD;
          S_PAD:   nxt_state = S_FCS;
          S_FCS:   nxt_state = S_IFG;
          default: nxt_state = state;
        endcase
      end else begin
        nxt_byte = byte_cnt + 7'd1;
      end
    end
    nxt_en = (nxt_state != S_IDLE) && (nxt_state != S_IFG);
  end

  // CRC folds in the dibit on the wire; it restarts during SFD
  always_comb begin
    case (state)
      S_SFD:               crc_nxt = '1;
      S_HDR, S_PAY, S_PAD: crc_nxt = crc_dibit(crc, tx_d);
      default:             crc_nxt = crc;
    endcase
  end

  // Byte and dibit for the next slot; FCS uses the CRC including the last pad dibit
  always_comb begin
    case (nxt_state)
      S_PRE:   cur_byte = 8'h55;
      S_SFD:   cur_byte = 8'hD5;
      S_HDR:   cur_byte = hdr_w[{4'd13 - nxt_byte[3:0], 3'b111} -: 8];
      S_PAY:   cur_byte = pay_q[{~nxt_byte[3:0], 3'b111} -: 8];
      S_FCS:   cur_byte = fcs_w[{nxt_byte[1:0], 3'b000} +: 8];
      default: cur_byte = 8'h00;
    endcase
    nxt_dibit = cur_byte[{nxt_dib, 1'b0} +: 2];
  end

  // Frame FSM with registered ready/tx_en/tx_d
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      byte_cnt <= '0;
      dib_cnt  <= '0;
      crc      <= '1;
      pay_q    <= '0;
      dst_q    <= '0;
      ready    <= 1'b0;
      tx_en    <= 1'b0;
      tx_d     <= 2'b00;
    end else if (state == S_IDLE) begin
      if (valid && ready) begin
        state    <= S_PRE;
        byte_cnt <= '0;
        dib_cnt  <= '0;
        pay_q    <= data;
        dst_q    <= dst_mac;
        ready    <= 1'b0;
        tx_en    <= 1'b1;
        tx_d     <= 2'b01;
      end else begin
        ready <= 1'b1;
      end
    end else if (ifg_done) begin
      state    <= S_IDLE;
      byte_cnt <= '0;
      dib_cnt  <= '0;
      ready    <= 1'b1;
    end else if (step) begin
      state    <= nxt_state;
      byte_cnt <= nxt_byte;
      dib_cnt  <= nxt_dib;
      crc      <= crc_nxt;
      tx_en    <= nxt_en;
      tx_d     <= nxt_en ? nxt_dibit : 2'b00;
    end
  end

endmodule
